// File: rtl/hr_bridge_xfer_fifo_if.sv
// Bridge <-> transfer-FIFO handshake bundle.
// The bridge (master) pushes/pops; the FIFO (slave) returns head flit,
// occupancy, back-pressure and sticky error flags.
interface hr_bridge_xfer_fifo_if #(
  parameter int WIDTH = 144,
  parameter int PTR_W = 2
);

  logic             enQ_i;
  logic [WIDTH-1:0] flit_i;
  logic             deQ_i;
  logic [WIDTH-1:0] flit_o;
  logic             valid_o;
  logic             bfull_o;
  logic [PTR_W:0]   count_o;
  logic             ovf_o;
  logic             udf_o;

  modport master (
    output enQ_i,
    output flit_i,
    output deQ_i,
    input  flit_o,
    input  valid_o,
    input  bfull_o,
    input  count_o,
    input  ovf_o,
    input  udf_o
  );

  modport slave (
    input  enQ_i,
    input  flit_i,
    input  deQ_i,
    output flit_o,
    output valid_o,
    output bfull_o,
    output count_o,
    output ovf_o,
    output udf_o
  );

endinterface

// File: rtl/hr_bridge_xfer_fifo.sv
// Transfer buffer between the hierarchical-ring bridge and one ring port.
// Circular buffer with explicit occupancy count. The head flit is presented
// combinationally from registered state only; bfull carries a reserve margin
// so a bufferless ring can stop injecting before the buffer actually fills.
module hr_bridge_xfer_fifo #(
  parameter int WIDTH   = 144,
  parameter int DEPTH   = 4,
  parameter int PTR_W   = 2,
  parameter int RESERVE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  hr_bridge_xfer_fifo_if.slave    bus
);

  localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   BFULL_THR = (PTR_W+1)'(DEPTH - RESERVE);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ZERO  = '0;

  // Back-pressure decision on post-edge occupancy.
  function automatic logic bfull_of(input logic [PTR_W:0] occ);
    return (occ >= BFULL_THR);
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_next;
  logic             push_acc;
  logic             pop_acc;
  logic             ovf;
  logic             udf;
  logic             bfull;

  // Accept/reject decisions and next occupancy.
  always_comb begin
    pop_acc    = bus.deQ_i && (count != CNT_ZERO);
    push_acc   = bus.enQ_i && ((count < DEPTH_C) || pop_acc);
    count_next = count + {{PTR_W{1'b0}}, push_acc} - {{PTR_W{1'b0}}, pop_acc};
  end

  // Control state: pointers, count, registered bfull, sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      bfull  <= 1'b0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_acc)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_next;
      bfull <= bfull_of(count_next);
      if (bus.enQ_i && !push_acc) ovf <= 1'b1;
      if (bus.deQ_i && !pop_acc)  udf <= 1'b1;
    end
  end

  // Flit storage; contents are left untouched by reset (count gates reads).
  always_ff @(posedge clk) begin
    if (!rst && push_acc) mem[wr_ptr] <= bus.flit_i;
  end

  // Output view derived only from registered state.
  always_comb begin
    bus.flit_o  = (count != CNT_ZERO) ? mem[rd_ptr] : '0;
    bus.valid_o = (count != CNT_ZERO);
    bus.bfull_o = bfull;
    bus.count_o = count;
    bus.ovf_o   = ovf;
    bus.udf_o   = udf;
  end

endmodule

// File: tb/tb_hr_bridge_xfer_fifo.sv
// Self-checking bench for hr_bridge_xfer_fifo: directed scenarios with
// constant expectations plus a randomized run against a queue-based model.
module tb_hr_bridge_xfer_fifo;

  localparam int W       = 144;
  localparam int DEPTH   = 4;
  localparam int PTR_W   = 2;
  localparam int RESERVE = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hr_bridge_xfer_fifo_if #(.WIDTH(W), .PTR_W(PTR_W)) bus ();

  hr_bridge_xfer_fifo #(
    .WIDTH(W), .DEPTH(DEPTH), .PTR_W(PTR_W), .RESERVE(RESERVE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a plain queue of flits plus sticky flags.
  logic [W-1:0] q[$];
  logic         m_ovf;
  logic         m_udf;

  // Drive one cycle of inputs, clock it, advance the model, settle 1 time unit.
  task automatic step(input logic r, input logic e, input logic [W-1:0] f, input logic d);
    logic can_pop;
    logic can_push;
    rst        = r;
    bus.enQ_i  = e;
    bus.flit_i = f;
    bus.deQ_i  = d;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      can_pop  = d && (q.size() > 0);
      can_push = e && ((q.size() < DEPTH) || can_pop);
      if (d && !can_pop)  m_udf = 1'b1;
      if (e && !can_push) m_ovf = 1'b1;
      if (can_pop)  void'(q.pop_front());
      if (can_push) q.push_back(f);
    end
    #1;
    rst       = 1'b0;
    bus.enQ_i = 1'b0;
    bus.deQ_i = 1'b0;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    do_reset();
    repeat (3) step(1'b0, 1'b0, '0, 1'b0);
    n_checks++; if (bus.flit_o !== '0) begin n_fail++; $display("FAIL reset_flit got=%h want=0", bus.flit_o); end
    n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", bus.valid_o); end
    n_checks++; if (bus.bfull_o !== 1'b0) begin n_fail++; $display("FAIL reset_bfull got=%b want=0", bus.bfull_o); end
    n_checks++; if (bus.count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d want=0", bus.count_o); end
    n_checks++; if (bus.ovf_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b want=0", bus.ovf_o); end
    n_checks++; if (bus.udf_o !== 1'b0) begin n_fail++; $display("FAIL reset_udf got=%b want=0", bus.udf_o); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    step(1'b0, 1'b1, 144'hA1, 1'b0);
    n_checks++; if (bus.flit_o !== 144'hA1) begin n_fail++; $display("FAIL fd_first_flit got=%h want=a1", bus.flit_o); end
    n_checks++; if (bus.count_o !== 3'd1) begin n_fail++; $display("FAIL fd_count1 got=%0d want=1", bus.count_o); end
    step(1'b0, 1'b1, 144'hB2, 1'b0);
    n_checks++; if (bus.bfull_o !== 1'b0) begin n_fail++; $display("FAIL fd_bfull_at2 got=%b want=0", bus.bfull_o); end
    step(1'b0, 1'b1, 144'hC3, 1'b0);
    n_checks++; if (bus.count_o !== 3'd3) begin n_fail++; $display("FAIL fd_count3 got=%0d want=3", bus.count_o); end
    n_checks++; if (bus.bfull_o !== 1'b1) begin n_fail++; $display("FAIL fd_bfull_at3 got=%b want=1", bus.bfull_o); end
    n_checks++; if (bus.flit_o !== 144'hA1) begin n_fail++; $display("FAIL fd_head_held got=%h want=a1", bus.flit_o); end
    step(1'b0, 1'b0, '0, 1'b1);
    n_checks++; if (bus.flit_o !== 144'hB2) begin n_fail++; $display("FAIL fd_pop1 got=%h want=b2", bus.flit_o); end
    n_checks++; if (bus.bfull_o !== 1'b0) begin n_fail++; $display("FAIL fd_bfull_drop got=%b want=0", bus.bfull_o); end
    step(1'b0, 1'b0, '0, 1'b1);
    n_checks++; if (bus.flit_o !== 144'hC3) begin n_fail++; $display("FAIL fd_pop2 got=%h want=c3", bus.flit_o); end
    step(1'b0, 1'b0, '0, 1'b1);
    n_checks++; if (bus.flit_o !== '0) begin n_fail++; $display("FAIL fd_pop3 got=%h want=0", bus.flit_o); end
    n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL fd_valid_end got=%b want=0", bus.valid_o); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, W'(i), 1'b0);
    n_checks++; if (bus.ovf_o !== 1'b0) begin n_fail++; $display("FAIL ovf_early got=%b want=0", bus.ovf_o); end
    step(1'b0, 1'b1, W'(5), 1'b0);
    n_checks++; if (bus.ovf_o !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b want=1", bus.ovf_o); end
    n_checks++; if (bus.count_o !== 3'd4) begin n_fail++; $display("FAIL ovf_count got=%0d want=4", bus.count_o); end
    for (int i = 1; i <= 4; i++) begin
      n_checks++; if (bus.flit_o !== W'(i)) begin n_fail++; $display("FAIL ovf_order got=%h want=%h", bus.flit_o, W'(i)); end
      step(1'b0, 1'b0, '0, 1'b1);
    end
    n_checks++; if (bus.ovf_o !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b want=1", bus.ovf_o); end
  endtask

  task automatic test_full_push_pop();
    logic [W-1:0] exp_order [4];
    exp_order = '{W'(2), W'(3), W'(4), W'(9)};
    do_reset();
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, W'(i), 1'b0);
    step(1'b0, 1'b1, W'(9), 1'b1);
    n_checks++; if (bus.count_o !== 3'd4) begin n_fail++; $display("FAIL fpp_count got=%0d want=4", bus.count_o); end
    n_checks++; if (bus.ovf_o !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf got=%b want=0", bus.ovf_o); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.flit_o !== exp_order[i]) begin n_fail++; $display("FAIL fpp_order got=%h want=%h", bus.flit_o, exp_order[i]); end
      step(1'b0, 1'b0, '0, 1'b1);
    end
    n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL fpp_empty got=%b want=0", bus.valid_o); end
  endtask

  task automatic test_empty_push_pop();
    do_reset();
    step(1'b0, 1'b1, 144'h77, 1'b1);
    n_checks++; if (bus.udf_o !== 1'b1) begin n_fail++; $display("FAIL epp_udf got=%b want=1", bus.udf_o); end
    n_checks++; if (bus.count_o !== 3'd1) begin n_fail++; $display("FAIL epp_count got=%0d want=1", bus.count_o); end
    n_checks++; if (bus.flit_o !== 144'h77) begin n_fail++; $display("FAIL epp_flit got=%h want=77", bus.flit_o); end
  endtask

  task automatic test_wrap();
    do_reset();
    step(1'b0, 1'b1, W'(1), 1'b0);
    step(1'b0, 1'b1, W'(2), 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, W'(3 + i), 1'b1);
      n_checks++; if (bus.flit_o !== W'(2 + i)) begin n_fail++; $display("FAIL wrap_head got=%h want=%h", bus.flit_o, W'(2 + i)); end
      n_checks++; if (bus.count_o !== 3'd2) begin n_fail++; $display("FAIL wrap_count got=%0d want=2", bus.count_o); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, W'(16 * i), 1'b0);
    step(1'b1, 1'b1, 144'hEE, 1'b0);
    n_checks++; if (bus.count_o !== 3'd0) begin n_fail++; $display("FAIL rmid_count got=%0d want=0", bus.count_o); end
    n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got=%b want=0", bus.valid_o); end
    n_checks++; if (bus.bfull_o !== 1'b0) begin n_fail++; $display("FAIL rmid_bfull got=%b want=0", bus.bfull_o); end
    n_checks++; if (bus.flit_o !== '0) begin n_fail++; $display("FAIL rmid_flit got=%h want=0", bus.flit_o); end
  endtask

  task automatic test_random();
    logic [W-1:0] f;
    logic         e;
    logic         d;
    logic [W-1:0] exp_flit;
    int           occ;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      f = {16'($urandom()), $urandom(), $urandom(), $urandom(), $urandom()};
      e = ($urandom_range(0, 99) < 60);
      d = ($urandom_range(0, 99) < 45);
      step((n % 150) == 149, e, f, d);
      occ      = q.size();
      exp_flit = (occ > 0) ? q[0] : '0;
      n_checks++; if (bus.flit_o !== exp_flit) begin n_fail++; $display("FAIL rnd_flit cyc=%0d got=%h want=%h", n, bus.flit_o, exp_flit); end
      n_checks++; if (bus.count_o !== 3'(occ)) begin n_fail++; $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", n, bus.count_o, occ); end
      n_checks++; if (bus.valid_o !== (occ > 0)) begin n_fail++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", n, bus.valid_o, occ > 0); end
      n_checks++; if (bus.bfull_o !== (occ >= DEPTH - RESERVE)) begin n_fail++; $display("FAIL rnd_bfull cyc=%0d got=%b want=%b", n, bus.bfull_o, occ >= DEPTH - RESERVE); end
      n_checks++; if (bus.ovf_o !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf cyc=%0d got=%b want=%b", n, bus.ovf_o, m_ovf); end
      n_checks++; if (bus.udf_o !== m_udf) begin n_fail++; $display("FAIL rnd_udf cyc=%0d got=%b want=%b", n, bus.udf_o, m_udf); end
    end
  endtask

  initial begin
    bus.enQ_i  = 1'b0;
    bus.deQ_i  = 1'b0;
    bus.flit_i = '0;
    m_ovf      = 1'b0;
    m_udf      = 1'b0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

endmodule
